// File: rtl/control_pkg.sv
// Shared definitions for the DLX Decode-stage control decoder.
// Holds the OpCode/Function constants, the output field encodings and the
// packed control-word type used between the decode logic and the reset mask.
package control_pkg;

  // Primary opcodes (instruction bits 31:26)
  localparam logic [0:5] OpRtype = 6'h00;
  localparam logic [0:5] OpFtype = 6'h01;
  localparam logic [0:5] OpJ     = 6'h02;
  localparam logic [0:5] OpJal   = 6'h03;
  localparam logic [0:5] OpBeqz  = 6'h04;
  localparam logic [0:5] OpBnez  = 6'h05;
  localparam logic [0:5] OpBfpt  = 6'h06;
  localparam logic [0:5] OpBfpf  = 6'h07;
  localparam logic [0:5] OpAddi  = 6'h08;
  localparam logic [0:5] OpAddui = 6'h09;
  localparam logic [0:5] OpSubi  = 6'h0A;
  localparam logic [0:5] OpSubui = 6'h0B;
  localparam logic [0:5] OpAndi  = 6'h0C;
  localparam logic [0:5] OpOri   = 6'h0D;
  localparam logic [0:5] OpXori  = 6'h0E;
  localparam logic [0:5] OpLhi   = 6'h0F;
  localparam logic [0:5] OpJr    = 6'h12;
  localparam logic [0:5] OpJalr  = 6'h13;
  localparam logic [0:5] OpSlli  = 6'h14;
  localparam logic [0:5] OpSrli  = 6'h16;
  localparam logic [0:5] OpSrai  = 6'h17;
  localparam logic [0:5] OpSeqi  = 6'h18;
  localparam logic [0:5] OpSnei  = 6'h19;
  localparam logic [0:5] OpSlti  = 6'h1A;
  localparam logic [0:5] OpSgti  = 6'h1B;
  localparam logic [0:5] OpSlei  = 6'h1C;
  localparam logic [0:5] OpSgei  = 6'h1D;
  localparam logic [0:5] OpLb    = 6'h20;
  localparam logic [0:5] OpLh    = 6'h21;
  localparam logic [0:5] OpLw    = 6'h23;
  localparam logic [0:5] OpLbu   = 6'h24;
  localparam logic [0:5] OpLhu   = 6'h25;
  localparam logic [0:5] OpLf    = 6'h26;
  localparam logic [0:5] OpSb    = 6'h28;
  localparam logic [0:5] OpSh    = 6'h29;
  localparam logic [0:5] OpSw    = 6'h2B;
  localparam logic [0:5] OpSf    = 6'h2E;

  // R-type Function codes (OpCode 0x00)
  localparam logic [0:5] FnSll     = 6'h04;
  localparam logic [0:5] FnSrl     = 6'h06;
  localparam logic [0:5] FnSra     = 6'h07;
  localparam logic [0:5] FnAdd     = 6'h20;
  localparam logic [0:5] FnAddu    = 6'h21;
  localparam logic [0:5] FnSub     = 6'h22;
  localparam logic [0:5] FnSubu    = 6'h23;
  localparam logic [0:5] FnAnd     = 6'h24;
  localparam logic [0:5] FnOr      = 6'h25;
  localparam logic [0:5] FnXor     = 6'h26;
  localparam logic [0:5] FnSeq     = 6'h28;
  localparam logic [0:5] FnSne     = 6'h29;
  localparam logic [0:5] FnSlt     = 6'h2A;
  localparam logic [0:5] FnSgt     = 6'h2B;
  localparam logic [0:5] FnSle     = 6'h2C;
  localparam logic [0:5] FnSge     = 6'h2D;
  localparam logic [0:5] FnMovf    = 6'h32;
  localparam logic [0:5] FnMovfp2i = 6'h34;
  localparam logic [0:5] FnMovi2fp = 6'h35;

  // FP-type Function codes (OpCode 0x01)
  localparam logic [0:5] FnAddf  = 6'h00;
  localparam logic [0:5] FnSubf  = 6'h01;
  localparam logic [0:5] FnMultf = 6'h02;
  localparam logic [0:5] FnDivf  = 6'h03;
  localparam logic [0:5] FnMult  = 6'h0E;
  localparam logic [0:5] FnMultu = 6'h16;

  // Writeback source
  localparam logic [0:1] DinAlu  = 2'b00;
  localparam logic [0:1] DinMem  = 2'b01;
  localparam logic [0:1] DinLink = 2'b10;
  localparam logic [0:1] DinFpu  = 2'b11;

  // Fetch/branch control
  localparam logic [0:1] JmpSeq    = 2'b00;
  localparam logic [0:1] JmpBranch = 2'b01;
  localparam logic [0:1] JmpImm    = 2'b10;
  localparam logic [0:1] JmpReg    = 2'b11;

  // ALU operation
  localparam logic [0:2] AluAdd   = 3'b000;
  localparam logic [0:2] AluSub   = 3'b001;
  localparam logic [0:2] AluAnd   = 3'b010;
  localparam logic [0:2] AluOr    = 3'b011;
  localparam logic [0:2] AluXor   = 3'b100;
  localparam logic [0:2] AluShift = 3'b101;
  localparam logic [0:2] AluSeta  = 3'b110;
  localparam logic [0:2] AluSetb  = 3'b111;

  // ALU sub-select, grouped by the ALUOp they qualify
  localparam logic [0:1] CruftSigned   = 2'b00;
  localparam logic [0:1] CruftUnsigned = 2'b01;
  localparam logic [0:1] CruftSll      = 2'b00;
  localparam logic [0:1] CruftSrl      = 2'b10;
  localparam logic [0:1] CruftSra      = 2'b11;
  localparam logic [0:1] CruftEq       = 2'b00;
  localparam logic [0:1] CruftNe       = 2'b01;
  localparam logic [0:1] CruftLt       = 2'b10;
  localparam logic [0:1] CruftGt       = 2'b11;
  localparam logic [0:1] CruftLe       = 2'b00;
  localparam logic [0:1] CruftGe       = 2'b01;
  localparam logic [0:1] CruftLhi      = 2'b10;
  localparam logic [0:1] CruftPassA    = 2'b11;

  // FPU operation
  localparam logic [0:2] FpuNone  = 3'b000;
  localparam logic [0:2] FpuAddf  = 3'b001;
  localparam logic [0:2] FpuSubf  = 3'b010;
  localparam logic [0:2] FpuMultf = 3'b011;
  localparam logic [0:2] FpuDivf  = 3'b100;
  localparam logic [0:2] FpuMult  = 3'b101;
  localparam logic [0:2] FpuMultu = 3'b110;

  // Memory access size
  localparam logic [0:1] MemByte = 2'b00;
  localparam logic [0:1] MemHalf = 2'b01;
  localparam logic [0:1] MemWord = 2'b10;

  typedef struct packed {
    logic [0:1] din_src;
    logic       reg_we;
    logic       fp_dest;
    logic       reg_dest;
    logic [0:1] jump_type;
    logic       cond_src;
    logic       branch_cond;
    logic       fp_src;
    logic [0:2] alu_op;
    logic [0:1] alu_cruft;
    logic [0:2] fpu_op;
    logic       alu_src;
    logic       ext_imm;
    logic [0:1] mem_size;
    logic       mem_we;
    logic       ext_mem;
  } ctrl_t;

endpackage

// File: rtl/control_if.sv
// Decode-stage bundle: instruction fields in, control word out.
//   master : instruction source (drives OpCode/Function, observes controls)
//   slave  : decoder (reads OpCode/Function, drives every control signal)
interface control_if;
  logic [0:5] OpCode;
  logic [0:5] Function;
  logic [0:1] DInSrc;
  logic       RegWE;
  logic       FPDest;
  logic       RegDest;
  logic [0:1] JumpType;
  logic       CondSrc;
  logic       BranchCond;
  logic       FPSrc;
  logic [0:2] ALUOp;
  logic [0:1] ALUCruft;
  logic [0:2] FPUOp;
  logic       ALUSrc;
  logic       ExtImm;
  logic [0:1] MEMSize;
  logic       MEMWE;
  logic       ExtMEM;

  modport master (
    output OpCode, Function,
    input  DInSrc, RegWE, FPDest, RegDest, JumpType, CondSrc, BranchCond, FPSrc,
           ALUOp, ALUCruft, FPUOp, ALUSrc, ExtImm, MEMSize, MEMWE, ExtMEM
  );

  modport slave (
    input  OpCode, Function,
    output DInSrc, RegWE, FPDest, RegDest, JumpType, CondSrc, BranchCond, FPSrc,
           ALUOp, ALUCruft, FPUOp, ALUSrc, ExtImm, MEMSize, MEMWE, ExtMEM
  );
endinterface

// File: rtl/control_alu_decode.sv
// R-type Function decoder: maps Function to ALUOp/ALUCruft.
//   func      in  R-type Function field
//   alu_op    out ALU operation
//   alu_cruft out ALU sub-select
//   valid     out Function is a supported R-type operation
module control_alu_decode
  import control_pkg::*;
(
  input  logic [0:5] func,
  output logic [0:2] alu_op,
  output logic [0:1] alu_cruft,
  output logic       valid
);

  always_comb begin
    alu_op    = AluAdd;
    alu_cruft = CruftSigned;
    valid     = 1'b1;
    case (func)
      FnSll:     begin alu_op = AluShift; alu_cruft = CruftSll;      end
      FnSrl:     begin alu_op = AluShift; alu_cruft = CruftSrl;      end
      FnSra:     begin alu_op = AluShift; alu_cruft = CruftSra;      end
      FnAdd:     begin alu_op = AluAdd;   alu_cruft = CruftSigned;   end
      FnAddu:    begin alu_op = AluAdd;   alu_cruft = CruftUnsigned; end
      FnSub:     begin alu_op = AluSub;   alu_cruft = CruftSigned;   end
      FnSubu:    begin alu_op = AluSub;   alu_cruft = CruftUnsigned; end
      FnAnd:     alu_op = AluAnd;
      FnOr:      alu_op = AluOr;
      FnXor:     alu_op = AluXor;
      FnSeq:     begin alu_op = AluSeta;  alu_cruft = CruftEq;       end
      FnSne:     begin alu_op = AluSeta;  alu_cruft = CruftNe;       end
      FnSlt:     begin alu_op = AluSeta;  alu_cruft = CruftLt;       end
      FnSgt:     begin alu_op = AluSeta;  alu_cruft = CruftGt;       end
      FnSle:     begin alu_op = AluSetb;  alu_cruft = CruftLe;       end
      FnSge:     begin alu_op = AluSetb;  alu_cruft = CruftGe;       end
      // Register moves all route operand A straight through the ALU
      FnMovf, FnMovfp2i, FnMovi2fp: begin alu_op = AluSetb; alu_cruft = CruftPassA; end
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/control.sv
// DLX Decode-stage main control decoder. Purely combinational; rst_n low masks
// every control output to the all-zero NOP pattern.
//   clk   in   pipeline clock (not used by the decode)
//   rst_n in   asynchronous active-low reset mask
//   bus   slave  OpCode/Function in, control word out
module control
  import control_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  control_if.slave bus
);

  ctrl_t      ctrl;
  logic [0:2] r_alu_op;
  logic [0:1] r_alu_cruft;
  logic       r_valid;
  logic       imm_op;
  logic       unused_clk;

  assign unused_clk = clk;

  control_alu_decode u_alu_decode (
    .func      (bus.Function),
    .alu_op    (r_alu_op),
    .alu_cruft (r_alu_cruft),
    .valid     (r_valid)
  );

  always_comb begin
    ctrl   = '0;
    imm_op = 1'b0;
    case (bus.OpCode)
      OpRtype: begin
        if (r_valid) begin
          ctrl.reg_we    = 1'b1;
          ctrl.reg_dest  = 1'b1;
          ctrl.alu_op    = r_alu_op;
          ctrl.alu_cruft = r_alu_cruft;
          ctrl.fp_src    = (bus.Function == FnMovf) || (bus.Function == FnMovfp2i);
          ctrl.fp_dest   = (bus.Function == FnMovf) || (bus.Function == FnMovi2fp);
        end
      end
      OpFtype: begin
        case (bus.Function)
          FnAddf:  ctrl.fpu_op = FpuAddf;
          FnSubf:  ctrl.fpu_op = FpuSubf;
          FnMultf: ctrl.fpu_op = FpuMultf;
          FnDivf:  ctrl.fpu_op = FpuDivf;
          FnMult:  ctrl.fpu_op = FpuMult;
          FnMultu: ctrl.fpu_op = FpuMultu;
          default: ctrl.fpu_op = FpuNone;
        endcase
        if (ctrl.fpu_op != FpuNone) begin
          ctrl.reg_we   = 1'b1;
          ctrl.reg_dest = 1'b1;
          ctrl.fp_src   = 1'b1;
          ctrl.fp_dest  = 1'b1;
          ctrl.din_src  = DinFpu;
        end
      end
      OpAddi:  begin imm_op = 1'b1; ctrl.ext_imm = 1'b1; end
      OpSubi:  begin imm_op = 1'b1; ctrl.ext_imm = 1'b1; ctrl.alu_op = AluSub; end
      OpSeqi:  begin imm_op = 1'b1; ctrl.ext_imm = 1'b1; ctrl.alu_op = AluSeta; end
      OpSnei:  begin
        imm_op = 1'b1; ctrl.ext_imm = 1'b1; ctrl.alu_op = AluSeta; ctrl.alu_cruft = CruftNe;
      end
      OpSlti:  begin
        imm_op = 1'b1; ctrl.ext_imm = 1'b1; ctrl.alu_op = AluSeta; ctrl.alu_cruft = CruftLt;
      end
      OpSgti:  begin
        imm_op = 1'b1; ctrl.ext_imm = 1'b1; ctrl.alu_op = AluSeta; ctrl.alu_cruft = CruftGt;
      end
      OpSlei:  begin imm_op = 1'b1; ctrl.ext_imm = 1'b1; ctrl.alu_op = AluSetb; end
      OpSgei:  begin
        imm_op = 1'b1; ctrl.ext_imm = 1'b1; ctrl.alu_op = AluSetb; ctrl.alu_cruft = CruftGe;
      end
      OpAddui: begin imm_op = 1'b1; ctrl.alu_cruft = CruftUnsigned; end
      OpSubui: begin imm_op = 1'b1; ctrl.alu_op = AluSub; ctrl.alu_cruft = CruftUnsigned; end
      OpAndi:  begin imm_op = 1'b1; ctrl.alu_op = AluAnd; end
      OpOri:   begin imm_op = 1'b1; ctrl.alu_op = AluOr; end
      OpXori:  begin imm_op = 1'b1; ctrl.alu_op = AluXor; end
      OpLhi:   begin imm_op = 1'b1; ctrl.alu_op = AluSetb; ctrl.alu_cruft = CruftLhi; end
      OpSlli:  begin imm_op = 1'b1; ctrl.alu_op = AluShift; ctrl.alu_cruft = CruftSll; end
      OpSrli:  begin imm_op = 1'b1; ctrl.alu_op = AluShift; ctrl.alu_cruft = CruftSrl; end
      OpSrai:  begin imm_op = 1'b1; ctrl.alu_op = AluShift; ctrl.alu_cruft = CruftSra; end
      OpLb, OpLh, OpLw, OpLbu, OpLhu, OpLf: begin
        imm_op       = 1'b1;
        ctrl.ext_imm = 1'b1;
        ctrl.din_src = DinMem;
        ctrl.ext_mem = (bus.OpCode == OpLb) || (bus.OpCode == OpLh);
        ctrl.fp_dest = (bus.OpCode == OpLf);
        if (bus.OpCode == OpLh || bus.OpCode == OpLhu) begin
          ctrl.mem_size = MemHalf;
        end else if (bus.OpCode == OpLw || bus.OpCode == OpLf) begin
          ctrl.mem_size = MemWord;
        end
      end
      OpSb, OpSh, OpSw, OpSf: begin
        ctrl.alu_src  = 1'b1;
        ctrl.ext_imm  = 1'b1;
        ctrl.mem_we   = 1'b1;
        ctrl.fp_src   = (bus.OpCode == OpSf);
        if (bus.OpCode == OpSh) begin
          ctrl.mem_size = MemHalf;
        end else if (bus.OpCode == OpSw || bus.OpCode == OpSf) begin
          ctrl.mem_size = MemWord;
        end
      end
      OpBeqz, OpBnez, OpBfpt, OpBfpf: begin
        ctrl.jump_type   = JmpBranch;
        ctrl.ext_imm     = 1'b1;
        ctrl.cond_src    = (bus.OpCode == OpBfpt) || (bus.OpCode == OpBfpf);
        ctrl.branch_cond = (bus.OpCode == OpBnez) || (bus.OpCode == OpBfpt);
      end
      OpJ:    ctrl.jump_type = JmpImm;
      OpJal:  begin ctrl.jump_type = JmpImm; ctrl.reg_we = 1'b1; ctrl.din_src = DinLink; end
      OpJr:   ctrl.jump_type = JmpReg;
      OpJalr: begin ctrl.jump_type = JmpReg; ctrl.reg_we = 1'b1; ctrl.din_src = DinLink; end
      default: ctrl = '0;
    endcase
    // Immediate-operand ALU forms (including loads) write rt
    if (imm_op) begin
      ctrl.alu_src = 1'b1;
      ctrl.reg_we  = 1'b1;
    end
  end

  // Reset is a combinational mask: asserting rst_n low forces NOP immediately
  assign bus.DInSrc     = rst_n ? ctrl.din_src     : '0;
  assign bus.RegWE      = rst_n ? ctrl.reg_we      : 1'b0;
  assign bus.FPDest     = rst_n ? ctrl.fp_dest     : 1'b0;
  assign bus.RegDest    = rst_n ? ctrl.reg_dest    : 1'b0;
  assign bus.JumpType   = rst_n ? ctrl.jump_type   : '0;
  assign bus.CondSrc    = rst_n ? ctrl.cond_src    : 1'b0;
  assign bus.BranchCond = rst_n ? ctrl.branch_cond : 1'b0;
  assign bus.FPSrc      = rst_n ? ctrl.fp_src      : 1'b0;
  assign bus.ALUOp      = rst_n ? ctrl.alu_op      : '0;
  assign bus.ALUCruft   = rst_n ? ctrl.alu_cruft   : '0;
  assign bus.FPUOp      = rst_n ? ctrl.fpu_op      : '0;
  assign bus.ALUSrc     = rst_n ? ctrl.alu_src     : 1'b0;
  assign bus.ExtImm     = rst_n ? ctrl.ext_imm     : 1'b0;
  assign bus.MEMSize    = rst_n ? ctrl.mem_size    : '0;
  assign bus.MEMWE      = rst_n ? ctrl.mem_we      : 1'b0;
  assign bus.ExtMEM     = rst_n ? ctrl.ext_mem     : 1'b0;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for the DLX control decoder: each directed step pushes
// its expected control word to a scoreboard queue, then pops and compares it
// against the settled DUT outputs.
module tb_control;

  typedef struct packed {
    logic [1:0] din_src;
    logic       reg_we;
    logic       fp_dest;
    logic       reg_dest;
    logic [1:0] jump_type;
    logic       cond_src;
    logic       branch_cond;
    logic       fp_src;
    logic [2:0] alu_op;
    logic [1:0] alu_cruft;
    logic [2:0] fpu_op;
    logic       alu_src;
    logic       ext_imm;
    logic [1:0] mem_size;
    logic       mem_we;
    logic       ext_mem;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  x;

  control_if io ();

  control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t observed();
    return {io.DInSrc, io.RegWE, io.FPDest, io.RegDest, io.JumpType, io.CondSrc,
            io.BranchCond, io.FPSrc, io.ALUOp, io.ALUCruft, io.FPUOp, io.ALUSrc,
            io.ExtImm, io.MEMSize, io.MEMWE, io.ExtMEM};
  endfunction

  // Drive an instruction, record its expectation, let it settle, then check.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input exp_t e,
                      input string tag);
    exp_t  obs;
    exp_t  want;
    string t;
    io.OpCode   = op;
    io.Function = fn;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    obs  = observed();
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, want);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    io.OpCode   = 6'h00;
    io.Function = 6'h20;

    // Reset held with ADD on the inputs
    x = '0;
    step(6'h00, 6'h20, x, "reset_add");

    // Release between clock edges: ADD must appear without a clock
    @(negedge clk);
    rst_n = 1'b1;
    x = '0; x.reg_we = 1; x.reg_dest = 1;
    step(6'h00, 6'h20, x, "release_add");

    x = '0; x.reg_we = 1; x.reg_dest = 1; x.alu_op = 3'b101; x.alu_cruft = 2'b11;
    step(6'h00, 6'h07, x, "sra");

    x = '0; x.reg_we = 1; x.reg_dest = 1; x.alu_op = 3'b110; x.alu_cruft = 2'b10;
    step(6'h00, 6'h2A, x, "slt");

    x = '0; x.reg_we = 1; x.reg_dest = 1; x.fp_src = 1; x.fp_dest = 1;
    x.alu_op = 3'b111; x.alu_cruft = 2'b11;
    step(6'h00, 6'h32, x, "movf");

    x = '0; x.reg_we = 1; x.reg_dest = 1; x.fp_src = 1; x.alu_op = 3'b111; x.alu_cruft = 2'b11;
    step(6'h00, 6'h34, x, "movfp2i");

    x = '0;
    step(6'h00, 6'h3F, x, "rtype_illegal");

    x = '0; x.reg_we = 1; x.alu_op = 3'b111; x.alu_cruft = 2'b10; x.alu_src = 1;
    step(6'h0F, 6'h00, x, "lhi");

    x = '0; x.reg_we = 1; x.alu_op = 3'b111; x.alu_cruft = 2'b01; x.alu_src = 1; x.ext_imm = 1;
    step(6'h1D, 6'h00, x, "sgei");

    x = '0; x.reg_we = 1; x.alu_op = 3'b101; x.alu_cruft = 2'b10; x.alu_src = 1;
    step(6'h16, 6'h00, x, "srli");

    x = '0; x.reg_we = 1; x.alu_op = 3'b001; x.alu_cruft = 2'b01; x.alu_src = 1;
    step(6'h0B, 6'h00, x, "subui");

    x = '0; x.din_src = 2'b01; x.reg_we = 1; x.alu_src = 1; x.ext_imm = 1; x.ext_mem = 1;
    step(6'h20, 6'h00, x, "lb");

    x = '0; x.din_src = 2'b01; x.reg_we = 1; x.alu_src = 1; x.ext_imm = 1; x.mem_size = 2'b01;
    step(6'h25, 6'h00, x, "lhu");

    x = '0; x.din_src = 2'b01; x.reg_we = 1; x.fp_dest = 1; x.alu_src = 1; x.ext_imm = 1;
    x.mem_size = 2'b10;
    step(6'h26, 6'h00, x, "lf");

    x = '0; x.mem_we = 1; x.alu_src = 1; x.ext_imm = 1; x.fp_src = 1; x.mem_size = 2'b10;
    step(6'h2E, 6'h00, x, "sf");

    x = '0; x.mem_we = 1; x.alu_src = 1; x.ext_imm = 1; x.mem_size = 2'b01;
    step(6'h29, 6'h00, x, "sh");

    x = '0; x.jump_type = 2'b01; x.cond_src = 1; x.branch_cond = 1; x.ext_imm = 1;
    step(6'h06, 6'h00, x, "bfpt");

    x = '0; x.jump_type = 2'b01; x.branch_cond = 1; x.ext_imm = 1;
    step(6'h05, 6'h00, x, "bnez");

    x = '0; x.jump_type = 2'b10; x.reg_we = 1; x.din_src = 2'b10;
    step(6'h03, 6'h00, x, "jal");

    x = '0; x.jump_type = 2'b11; x.reg_we = 1; x.din_src = 2'b10;
    step(6'h13, 6'h00, x, "jalr");

    x = '0; x.jump_type = 2'b10;
    step(6'h02, 6'h00, x, "j");

    x = '0; x.din_src = 2'b11; x.reg_we = 1; x.reg_dest = 1; x.fp_src = 1; x.fp_dest = 1;
    x.fpu_op = 3'b101;
    step(6'h01, 6'h0E, x, "mult");

    x = '0; x.din_src = 2'b11; x.reg_we = 1; x.reg_dest = 1; x.fp_src = 1; x.fp_dest = 1;
    x.fpu_op = 3'b100;
    step(6'h01, 6'h03, x, "divf");

    x = '0;
    step(6'h01, 6'h05, x, "ftype_illegal");
    step(6'h3F, 6'h00, x, "op_3f");
    step(6'h15, 6'h00, x, "nop_15");
    step(6'h27, 6'h00, x, "ld_27");
    step(6'h11, 6'h00, x, "trap_11");

    // Reset asserted mid-cycle masks a live LW decode, then release restores it
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    x = '0;
    step(6'h23, 6'h00, x, "reset_lw");
    rst_n = 1'b1;
    x = '0; x.din_src = 2'b01; x.reg_we = 1; x.alu_src = 1; x.ext_imm = 1; x.mem_size = 2'b10;
    step(6'h23, 6'h00, x, "release_lw");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control.md
# control

Main instruction decoder for the 5-stage pipelined DLX processor, placed in the Decode stage. It maps the 6-bit OpCode and 6-bit R-type Function fields to control signals for writeback, fetch/branch, register read, execute, and memory. Decode is purely combinational; the active-low asynchronous reset forces every control output to the NOP (all-zero) pattern.

## Interface
All vectors are declared big-endian [0:n]; index 0 is the MSB.

Parameters:
- none

Ports:
- clk  in  1  pipeline clock. Unused by the decode logic; present for uniformity. One clock.
- rst_n  in  1  asynchronous, active-low reset. While low, every output is 0.
- OpCode  in  [0:5]  instruction bits 31:26.
- Function  in  [0:5]  instruction bits 5:0. Used only when OpCode is 0x00 or 0x01.
- DInSrc  out  [0:1]  writeback source: 00 ALU, 01 memory, 10 link (PC+8), 11 FPU.
- RegWE  out  1  register-file write enable.
- FPDest  out  1  write the FP register file instead of the integer file.
- RegDest  out  1  destination select: 1 = rd, 0 = rt. When DInSrc=10, the destination is r31 regardless.
- JumpType  out  [0:1]  00 sequential, 01 conditional branch, 10 jump to immediate, 11 jump to register.
- CondSrc  out  1  branch condition source: 0 = rs1 tested against zero, 1 = FP status flag.
- BranchCond  out  1  branch taken when the condition is: 0 = zero/false, 1 = nonzero/true.
- FPSrc  out  1  source operands (and store data) come from the FP register file.
- ALUOp  out  [0:2]  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHIFT, 110 SETA, 111 SETB/MISC.
- ALUCruft  out  [0:1]  sub-select, meaning depends on ALUOp:
  - ADD/SUB: 00 signed, 01 unsigned.
  - SHIFT: 00 SLL, 10 SRL, 11 SRA.
  - SETA: 00 EQ, 01 NE, 10 LT, 11 GT.
  - SETB: 00 LE, 01 GE, 10 LHI (B<<16), 11 pass A.
  - All other ALUOps: 00.
- FPUOp  out  [0:2]  000 none, 001 ADDF, 010 SUBF, 011 MULTF, 100 DIVF, 101 MULT, 110 MULTU.
- ALUSrc  out  1  second ALU operand is the immediate.
- ExtImm  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- MEMSize  out  [0:1]  access size: 00 byte, 01 half, 10 word. Forced to 00 for non-memory instructions.
- MEMWE  out  1  data-memory write enable.
- ExtMEM  out  1  sign-extend the loaded value.

## Operation
- Default: any output not listed for an instruction is 0.
- Unlisted or illegal opcodes and functions decode to all-zero. This includes NOP 0x15, TRAP 0x11, RFE 0x10, MOVI2S 0x30, and MOVS2I 0x31.
- R-type, OpCode 0x00: RegWE=1, RegDest=1, DInSrc=00. ALUOp/ALUCruft by Function:
  - 04 SLL, 06 SRL, 07 SRA.
  - 20 ADD, 21 ADDU, 22 SUB, 23 SUBU.
  - 24 AND, 25 OR, 26 XOR.
  - 28 SEQ, 29 SNE, 2A SLT, 2B SGT, 2C SLE, 2D SGE.
- R-type moves, OpCode 0x00 (all use SETB/11 pass A):
  - 32 MOVF: FPSrc=1, FPDest=1.
  - 34 MOVFP2I: FPSrc=1.
  - 35 MOVI2FP: FPDest=1.
- FP-type, OpCode 0x01: RegWE=1, RegDest=1, FPSrc=1, FPDest=1, DInSrc=11.
  - FPUOp by Function: 00 ADDF, 01 SUBF, 02 MULTF, 03 DIVF, 0E MULT, 16 MULTU.
  - Any other Function decodes to all-zero.
- Immediate ALU ops: ALUSrc=1, RegWE=1, RegDest=0.
  - Sign-extended (ExtImm=1): 08 ADDI, 0A SUBI, 18-1D SEQI..SGEI.
  - Zero-extended (ExtImm=0): 09 ADDUI, 0B SUBUI, 0C ANDI, 0D ORI, 0E XORI, 0F LHI (SETB/10).
  - Shifts with ExtImm=0: 14 SLLI, 16 SRLI, 17 SRAI.
- Loads: ADD, ALUSrc=1, ExtImm=1, RegWE=1, RegDest=0, DInSrc=01.
  - 20 LB: MEMSize 00, ExtMEM=1.
  - 21 LH: MEMSize 01, ExtMEM=1.
  - 23 LW: MEMSize 10.
  - 24 LBU: MEMSize 00.
  - 25 LHU: MEMSize 01.
  - 26 LF: MEMSize 10, FPDest=1.
- Stores: ADD, ALUSrc=1, ExtImm=1, MEMWE=1, RegWE=0.
  - 28 SB: MEMSize 00.
  - 29 SH: MEMSize 01.
  - 2B SW: MEMSize 10.
  - 2E SF: MEMSize 10, FPSrc=1.
- Branches (JumpType=01, ExtImm=1), as CondSrc/BranchCond:
  - 04 BEQZ 0/0, 05 BNEZ 0/1, 06 BFPT 1/1, 07 BFPF 1/0.
- Jumps:
  - 02 J: JumpType 10.
  - 03 JAL: JumpType 10, RegWE=1, DInSrc=10.
  - 12 JR: JumpType 11.
  - 13 JALR: JumpType 11, RegWE=1, DInSrc=10.
- LD/SD (0x27/0x2F) are unsupported and decode to all-zero.

## Timing
- Fully combinational from OpCode/Function to all outputs. Zero-cycle latency; settles within the Decode cycle.
- No internal state; clk is not used by the decode logic.
- rst_n=0 forces all outputs to 0 immediately and asynchronously, overriding the inputs.
- Normal decode resumes combinationally on deassertion, with no cycle delay.
- Decoding of an instruction depends only on the current inputs. Reset applied while decoding simply masks the outputs.

## Structure
- Shared package control_pkg holds:
  - OpCode and Function constants.
  - Encodings for DInSrc, JumpType, ALUOp, ALUCruft, FPUOp and MEMSize.
- One sub-module, control_alu_decode, maps R-type Function to ALUOp/ALUCruft. The top level handles the OpCode case and the reset mask.

## Test plan
- rst_n=1, OpCode 00, Function 20 (ADD) -> DInSrc 00, RegWE 1, RegDest 1, ALUOp 000, ALUCruft 00, ALUSrc 0, JumpType 00, MEMWE 0.
- OpCode 00, Function 07 (SRA) -> ALUOp 101, ALUCruft 11. OpCode 0F (LHI) -> ALUOp 111, ALUCruft 10, ALUSrc 1, ExtImm 0, RegDest 0.
- Loads:
  - OpCode 20 (LB) -> DInSrc 01, MEMSize 00, ExtMEM 1, ExtImm 1.
  - OpCode 25 (LHU) -> MEMSize 01, ExtMEM 0.
  - OpCode 2E (SF) -> MEMWE 1, RegWE 0, FPSrc 1, MEMSize 10.
- Control flow:
  - OpCode 06 (BFPT) -> JumpType 01, CondSrc 1, BranchCond 1, RegWE 0.
  - OpCode 03 (JAL) -> JumpType 10, RegWE 1, DInSrc 10.
  - OpCode 13 (JALR) -> JumpType 11.
- OpCode 01, Function 0E (MULT) -> DInSrc 11, FPSrc 1, FPDest 1, RegWE 1, FPUOp 101.
- Reset and illegal codes:
  - OpCode 3F -> all outputs 0.
  - rst_n=0 with ADD applied -> all outputs 0.
  - Release rst_n -> ADD decode appears with no clock edge.
